wb_retire_tracer: RTL and testbench
===================================

Name: wb_retire_tracer

Overview:
- Consumer end of the MEM/WB pipeline buffer: samples every instruction retiring from the write-back stage and turns it into a trace record.
- Records are queued in a small FIFO and delivered over a valid/ready stream to the debug/commit-log port.
- Keeps a retire counter, a sequence tag and a drop counter, so the bench and debug host can detect lost retirements.
- Sits beside the WB stage, in parallel with the register-file write path; it never stalls the pipeline.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- SEQ_W, 16, width of the per-record sequence tag.

Ports:
- clk, input, 1, core clock.
- reset, input, 1, synchronous, active-high reset.
- wb_in, input, mem_wb_reg (136 bits), current MEM/WB buffer contents.
- wb_valid, input, 1, WB holds a real instruction (0 = bubble or flushed slot).
- trace_en, input, 1, capture enable.
- clear, input, 1, synchronous clear of FIFO, counters and flags.
- trace_valid, output, 1, head record available.
- trace_ready, input, 1, sink accepts the head record.
- trace_rec, output, trace_rec_t (SEQ_W+102 bits), head record.
- retire_cnt, output, 32, instructions retired while enabled.
- drop_cnt, output, 16, records lost to FIFO full.
- overflow, output, 1, sticky flag: at least one drop occurred.
- fifo_level, output, $clog2(DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset and clear:
  - reset (or clear) in cycle N: from N+1, all outputs are 0, FIFO is empty, pointers are 0, seq is 0.
  - Any in-flight capture or pop in that cycle is discarded.
  - reset takes priority over clear; clear takes priority over capture and pop.
- Capture condition: cap = wb_valid & trace_en, sampled at the clk rising edge.
- Record fields, computed combinationally from wb_in:
  - pc = wb_in.pc_plus_4 - 32'd4, modulo 2^32 (so pc_plus_4 = 0 gives 0xFFFFFFFC).
  - instr = Curr_Instr.
  - rd = wb_in.rd.
  - we = RegWrite & (rd != 0).
  - wdata by MemtoReg: 00 Alu_Result, 01 MemReadData, 10 pc_plus_4, 11 Alu_Result.
  - wdata is forced to 0 when we = 0.
  - seq = current seq register value.
- Counters on each cap:
  - seq increments, wrapping at 2^SEQ_W.
  - retire_cnt increments, wrapping at 2^32.
  - Both advance even when the record is dropped, so seq gaps mark drops.
- FIFO:
  - push = cap & (!full | pop).
  - pop = trace_valid & trace_ready.
  - Full with a pop in the same cycle: the push is accepted, no drop, level unchanged.
  - Empty with a push: trace_valid rises in the next cycle. Push-to-visible latency is 1 cycle; there is no same-cycle bypass.
  - Empty with pop: impossible, because trace_valid = 0.
- Drops:
  - A drop is cap & full & !pop.
  - On a drop: drop_cnt increments, saturating at 0xFFFF; overflow is set and held until reset or clear.
- Stream rules:
  - trace_rec is the head entry (show-ahead).
  - Once trace_valid is high, trace_rec is stable until popped.
  - trace_valid never drops without a pop.
- Pointers: rd/wr pointers carry one extra wrap bit.
  - full = pointers equal except the MSB.
  - empty = pointers equal.
  - fifo_level = wr - rd, using the extra bit.
- trace_en low: no capture and counters hold, but the FIFO keeps draining.

Decomposition:
- Shared pipeline-register package gets:
  - typedef trace_rec_t (packed struct: seq, pc, instr, rd, we, wdata);
  - localparam encodings for the MemtoReg select values.
- One natural sub-module: trace_fifo, a parameterised synchronous show-ahead FIFO with push/pop/full/empty/level.
- Capture, field-formatting and counter logic stay in wb_retire_tracer.

Test Plan:
- Reset, then 3 captures with wb_in.pc_plus_4 = 0x104/0x108/0x10C, MemtoReg = 00, Alu_Result = 5/6/7, rd = 1, RegWrite = 1, trace_ready = 1 -> records pc = 0x100/0x104/0x108, wdata = 5/6/7, seq = 0/1/2, each one cycle after capture; retire_cnt = 3.
- rd = 0 with RegWrite = 1, and separately RegWrite = 0 with rd = 5 -> we = 0 and wdata = 0 in both cases; MemtoReg = 10 with pc_plus_4 = 0x20 -> wdata = 0x20.
- trace_ready = 0 with DEPTH = 8 and 10 captures -> fifo_level = 8, drop_cnt = 2, overflow = 1; draining yields seq 0..7, and the next capture gets seq = 10.
- FIFO full, with capture and pop in the same cycle -> no drop, level stays 8, and the new record arrives in order.
- wb_valid = 1 with trace_en = 0 -> no record, retire_cnt unchanged; clear asserted with 4 queued entries -> next cycle trace_valid = 0, level = 0, seq = 0, overflow = 0.
- reset while trace_valid = 1 and a capture is pending -> next cycle every output is 0; the first capture after reset has seq = 0.

Source files
------------

// File: rtl/wb_retire_tracer_pkg.sv
// Shared MEM/WB pipeline-register types and the trace record produced at retirement.
// The MemtoReg encodings select the value that reaches the register file.
package wb_retire_tracer_pkg;

    localparam int TRACE_SEQ_W = 16;

    localparam logic [1:0] WB_SEL_ALU     = 2'b00;
    localparam logic [1:0] WB_SEL_MEM     = 2'b01;
    localparam logic [1:0] WB_SEL_PC4     = 2'b10;
    localparam logic [1:0] WB_SEL_ALU_ALT = 2'b11;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] Curr_Instr;
        logic [4:0]  rd;
        logic        RegWrite;
        logic [1:0]  MemtoReg;
        logic [31:0] Alu_Result;
        logic [31:0] MemReadData;
    } mem_wb_reg;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [31:0]            pc;
        logic [31:0]            instr;
        logic [4:0]             rd;
        logic                   we;
        logic [31:0]            wdata;
    } trace_rec_t;

    // Write-back mux: the value the register file would receive for this instruction.
    function automatic logic [31:0] wb_select(input mem_wb_reg w);
        logic [31:0] sel_v;
        case (w.MemtoReg)
            WB_SEL_ALU:     sel_v = w.Alu_Result;
            WB_SEL_MEM:     sel_v = w.MemReadData;
            WB_SEL_PC4:     sel_v = w.pc_plus_4;
            WB_SEL_ALU_ALT: sel_v = w.Alu_Result;
            default:        sel_v = w.Alu_Result;
        endcase
        return sel_v;
    endfunction

endpackage

// File: rtl/wb_retire_tracer_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers; the head reads as zero while empty.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level = wr_ptr_r - rd_ptr_r;

    // Pointer update; clear behaves like reset so pending push/pop are discarded.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !reset && !clear) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Show-ahead head entry, forced to zero while nothing is queued.
    always_comb begin
        dout = '0;
        if (empty) begin
            dout = '0;
        end else begin
            dout = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

endmodule

// File: rtl/wb_retire_tracer.sv
// Retirement tracer beside the WB stage: formats each retiring instruction into a trace
// record, queues it, and keeps retire/sequence/drop bookkeeping. Never stalls the pipeline.
module wb_retire_tracer
    import wb_retire_tracer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SEQ_W = TRACE_SEQ_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  mem_wb_reg              wb_in,
    input  logic                   wb_valid,
    input  logic                   trace_en,
    input  logic                   clear,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output trace_rec_t             trace_rec,
    output logic [31:0]            retire_cnt,
    output logic [15:0]            drop_cnt,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    logic [SEQ_W-1:0] seq_r;
    logic [31:0]      retire_r;
    logic [15:0]      drop_r;
    logic             overflow_r;

    logic       cap_s;
    logic       pop_s;
    logic       push_s;
    logic       drop_s;
    logic       full_s;
    logic       empty_s;
    logic       we_s;
    trace_rec_t rec_s;
    trace_rec_t head_s;

    // clear outranks capture and pop; the FIFO also discards them on clear.
    assign cap_s  = wb_valid & trace_en & ~clear;
    assign pop_s  = trace_valid & trace_ready & ~clear;
    assign push_s = cap_s & (~full_s | pop_s);
    assign drop_s = cap_s & full_s & ~pop_s;
    assign we_s   = wb_in.RegWrite & (wb_in.rd != 5'd0);

    // Record formatting from the current MEM/WB contents.
    always_comb begin
        rec_s       = '0;
        rec_s.seq   = TRACE_SEQ_W'(seq_r);
        rec_s.pc    = wb_in.pc_plus_4 - 32'd4;
        rec_s.instr = wb_in.Curr_Instr;
        rec_s.rd    = wb_in.rd;
        rec_s.we    = we_s;
        if (we_s) begin
            rec_s.wdata = wb_select(wb_in);
        end else begin
            rec_s.wdata = 32'd0;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(trace_rec_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push_s),
        .pop   (pop_s),
        .din   (rec_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (fifo_level)
    );

    // Bookkeeping: seq and retire count advance on every capture, dropped or not.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            seq_r      <= '0;
            retire_r   <= 32'd0;
            drop_r     <= 16'd0;
            overflow_r <= 1'b0;
        end else begin
            if (cap_s) begin
                seq_r    <= seq_r + SEQ_W'(1);
                retire_r <= retire_r + 32'd1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_r != 16'hFFFF) begin
                    drop_r <= drop_r + 16'd1;
                end
            end
        end
    end

    assign trace_valid = ~empty_s;
    assign trace_rec   = head_s;
    assign retire_cnt  = retire_r;
    assign drop_cnt    = drop_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_wb_retire_tracer.sv
// Directed plus random stimulus for wb_retire_tracer, checked against a queue-based model.
module tb_wb_retire_tracer;
    import wb_retire_tracer_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    mem_wb_reg  wb_in = '0;
    logic       wb_valid = 1'b0;
    logic       trace_en = 1'b0;
    logic       clear = 1'b0;
    logic       trace_valid;
    logic       trace_ready = 1'b0;
    trace_rec_t trace_rec;
    logic [31:0] retire_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic [3:0]  fifo_level;

    int errors = 0;
    int checks = 0;

    trace_rec_t  q[$];
    int unsigned m_seq = 0;
    int unsigned m_retire = 0;
    int unsigned m_drop = 0;
    bit          m_ovf = 1'b0;

    wb_retire_tracer #(.DEPTH(DEPTH), .SEQ_W(16)) dut (
        .clk(clk), .reset(reset), .wb_in(wb_in), .wb_valid(wb_valid),
        .trace_en(trace_en), .clear(clear), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_rec(trace_rec), .retire_cnt(retire_cnt),
        .drop_cnt(drop_cnt), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic trace_rec_t model_rec(input mem_wb_reg w, input int unsigned s);
        trace_rec_t r;
        r.seq   = 16'(s);
        r.pc    = w.pc_plus_4 - 32'd4;
        r.instr = w.Curr_Instr;
        r.rd    = w.rd;
        r.we    = w.RegWrite && (w.rd != 5'd0);
        if (!r.we)                       r.wdata = 32'd0;
        else if (w.MemtoReg == 2'b01)    r.wdata = w.MemReadData;
        else if (w.MemtoReg == 2'b10)    r.wdata = w.pc_plus_4;
        else                             r.wdata = w.Alu_Result;
        return r;
    endfunction

    task automatic check_all();
        trace_rec_t head;
        head = (q.size() > 0) ? q[0] : '0;
        chk("trace_valid", 128'(trace_valid), 128'(q.size() > 0));
        chk("trace_rec",   128'(trace_rec),   128'(head));
        chk("fifo_level",  128'(fifo_level),  128'(q.size()));
        chk("retire_cnt",  128'(retire_cnt),  128'(m_retire));
        chk("drop_cnt",    128'(drop_cnt),    128'(m_drop));
        chk("overflow",    128'(overflow),    128'(m_ovf));
    endtask

    // Advance the model by the inputs now applied, clock once, then compare.
    task automatic tick();
        bit pop;
        pop = (q.size() > 0) && trace_ready;
        if (reset || clear) begin
            q.delete();
            m_seq = 0; m_retire = 0; m_drop = 0; m_ovf = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (wb_valid && trace_en) begin
                if (q.size() < DEPTH) q.push_back(model_rec(wb_in, m_seq));
                else begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1'b1;
                end
                m_seq    = (m_seq + 1) % 65536;
                m_retire = m_retire + 1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_wb(input logic [31:0] pc4, input logic [1:0] m2r, input logic [31:0] alu,
                          input logic [4:0] rd, input logic rw);
        wb_in.pc_plus_4   = pc4;
        wb_in.Curr_Instr  = $urandom();
        wb_in.rd          = rd;
        wb_in.RegWrite    = rw;
        wb_in.MemtoReg    = m2r;
        wb_in.Alu_Result  = alu;
        wb_in.MemReadData = $urandom();
    endtask

    task automatic rand_wb();
        set_wb($urandom(), 2'($urandom_range(0, 3)), $urandom(), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)));
    endtask

    initial begin
        // Reset: everything reads zero afterwards.
        reset = 1'b1; tick(); reset = 1'b0;
        chk("reset_level", 128'(fifo_level), 128'(0));

        // Three captures streamed straight out.
        trace_en = 1'b1; trace_ready = 1'b1; wb_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_wb(32'h104 + 32'(4 * i), 2'b00, 32'(5 + i), 5'd1, 1'b1);
            tick();
            chk("pc_first3",    128'(trace_rec.pc),    128'(32'h100 + 32'(4 * i)));
            chk("wdata_first3", 128'(trace_rec.wdata), 128'(5 + i));
            chk("seq_first3",   128'(trace_rec.seq),   128'(i));
        end
        wb_valid = 1'b0; tick();
        chk("retire3", 128'(retire_cnt), 128'(3));

        // Write-enable masking and PC+4 write-back.
        wb_valid = 1'b1;
        set_wb(32'h200, 2'b00, 32'hDEAD, 5'd0, 1'b1); tick();
        chk("we_rd0", 128'({trace_rec.we, trace_rec.wdata}), 128'(0));
        set_wb(32'h204, 2'b00, 32'hBEEF, 5'd5, 1'b0); tick();
        chk("we_rw0", 128'({trace_rec.we, trace_rec.wdata}), 128'(0));
        set_wb(32'h20, 2'b10, 32'h1234, 5'd3, 1'b1); tick();
        chk("wdata_pc4", 128'(trace_rec.wdata), 128'(32'h20));
        wb_valid = 1'b0; tick();

        // Overflow: 10 captures into 8 entries.
        clear = 1'b1; tick(); clear = 1'b0;
        trace_ready = 1'b0; wb_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin rand_wb(); tick(); end
        chk("ovf_level", 128'(fifo_level), 128'(8));
        chk("ovf_drops", 128'(drop_cnt),   128'(2));
        chk("ovf_flag",  128'(overflow),   128'(1));
        wb_valid = 1'b0; trace_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_seq", 128'(trace_rec.seq), 128'(k));
            tick();
        end
        trace_ready = 1'b0; wb_valid = 1'b1; rand_wb(); tick();
        chk("seq_after_drop", 128'(trace_rec.seq), 128'(10));

        // Full with simultaneous capture and pop: accepted, no drop.
        for (int i = 0; i < 7; i++) begin rand_wb(); tick(); end
        chk("full_level", 128'(fifo_level), 128'(8));
        trace_ready = 1'b1; rand_wb(); tick();
        chk("fullpop_level", 128'(fifo_level), 128'(8));
        chk("fullpop_drops", 128'(drop_cnt),   128'(2));

        // trace_en low: no capture, the FIFO keeps draining.
        trace_en = 1'b0; rand_wb(); tick();
        chk("en_low_retire", 128'(retire_cnt), 128'(19));

        // Clear with four queued entries.
        trace_en = 1'b1; trace_ready = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 4; i++) begin rand_wb(); tick(); end
        wb_valid = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_valid", 128'(trace_valid), 128'(0));
        chk("clear_level", 128'(fifo_level),  128'(0));
        wb_valid = 1'b1; rand_wb(); tick();
        chk("clear_seq0", 128'(trace_rec.seq), 128'(0));

        // Reset with a visible record and a pending capture.
        rand_wb(); reset = 1'b1; tick(); reset = 1'b0;
        chk("reset_all", 128'({trace_valid, trace_rec, retire_cnt, drop_cnt, overflow, fifo_level}), 128'(0));
        rand_wb(); tick();
        chk("reset_seq0", 128'(trace_rec.seq), 128'(0));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            wb_valid    = 1'($urandom_range(0, 3) != 0);
            trace_en    = 1'($urandom_range(0, 7) != 0);
            trace_ready = 1'($urandom_range(0, 2) == 0);
            clear       = 1'($urandom_range(0, 60) == 0);
            rand_wb();
            tick();
        end
        clear = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
